// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers and mthi/mtlo writes.
// The result is computed from the operands seen at the accept edge and committed after a fixed latency.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mdstart,
  input  logic [2:0]  mdop,
  input  logic        hlsel,
  input  logic        hlwrite,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hlrdata
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  logic        start_acc;
  logic        hl_acc;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_calc;
  logic [31:0] r_calc;

  assign busy      = (state == RUN);
  assign start_acc = mdstart & ~req & ~busy & ~mdop[2];
  assign hl_acc    = hlwrite & ~req & ~busy & ~start_acc;
  assign hlrdata   = hlsel ? hi : lo;

  // Division runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 with no special case.
  always_comb begin
    prod   = '0;
    a_neg  = 1'b0;
    b_neg  = 1'b0;
    a_mag  = a;
    b_mag  = b;
    q_mag  = '0;
    r_mag  = '0;
    q_calc = '0;
    r_calc = '0;
    if (mdop[0])
      prod = {32'b0, a} * {32'b0, b};
    else
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    a_neg = ~mdop[0] & a[31];
    b_neg = ~mdop[0] & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    if (b != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    q_calc = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_calc = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= RUN;
            cnt   <= mdop[1] ? 4'd10 : 4'd5;
            if (mdop[1]) begin
              res_hi <= r_calc;
              res_lo <= q_calc;
              res_wr <= (b != 32'd0);
            end else begin
              res_hi <= prod[63:32];
              res_lo <= prod[31:0];
              res_wr <= 1'b1;
            end
          end else if (hl_acc) begin
            if (hlsel)
              hi <= a;
            else
              lo <= a;
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; reset is port `reset`, and `reset`=0 is reset.
REQ-002 SHALL have these ports; clock and reset are listed first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- req  input  1  exception/interrupt flush from M stage; blocks acceptance this cycle
- mdstart  input  1  start request for a mult/div in E stage
- mdop  input  3  000 mult, 001 multu, 010 div, 011 divu, 1xx reserved
- hlsel  input  1  0 selects LO, 1 selects HI
- hlwrite  input  1  mthi/mtlo write request
- a  input  32  operand rs (forwarded)
- b  input  32  operand rt (forwarded)
- busy  output  1  operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- hlrdata  output  32  mfhi/mflo data, hlsel ? hi : lo, combinational

Function
REQ-003 SHALL accept a start at a rising edge when mdstart=1, req=0, busy=0, and mdop[2]=0.
REQ-004 SHALL ignore mdstart when req=1, busy=1, or mdop is reserved (1xx); no state changes.
REQ-005 SHALL compute the result from a, b, and mdop sampled at the accept edge; later operand changes have no effect.
REQ-006 SHALL implement a 2-state FSM, IDLE and RUN:
- IDLE->RUN on accept.
- RUN->IDLE on the commit edge.
- busy=1 exactly in RUN.
REQ-007 SHALL use a 4-bit down-counter, loaded on accept:
- Load 5 for mult/multu, 10 for div/divu.
- Decrement each edge in RUN.
- Commit HI/LO and return to IDLE on the edge where the counter value is 1.
REQ-008 SHALL give latency so that, with accept at edge T, HI/LO update and busy falls at edge T+5 (mult) or T+10 (div); busy is high for exactly 5 or 10 cycles.
REQ-009 mult/multu SHALL form a 64-bit signed/unsigned product, with HI = bits 63:32 and LO = bits 31:0.
REQ-010 div/divu SHALL place the quotient in LO and the remainder in HI:
- Signed division truncates toward zero.
- Signed remainder takes the sign of the dividend a.
REQ-011 SHALL handle divide-by-zero (b=0) by accepting, running 10 cycles, and leaving HI/LO unchanged at commit.
REQ-012 SHALL give signed 0x80000000 / 0xFFFFFFFF the result LO=0x80000000, HI=0.
REQ-013 SHALL handle hlwrite as follows:
- Accept at an edge when hlwrite=1, req=0, busy=0.
- Load a into HI if hlsel=1, else into LO.
- The other register is unchanged.
REQ-014 SHALL ignore hlwrite while busy=1 or req=1.
REQ-015 SHALL give an accepted mdstart priority over hlwrite in the same cycle; the hlwrite is dropped.
REQ-016 SHALL NOT let req cancel an operation already in RUN; it completes and commits normally.
REQ-017 SHALL keep hi/lo holding their value at every edge with no commit or accepted hlwrite.
REQ-018 SHALL make hlrdata reflect current hi/lo registers only; there is no bypass of an in-flight result.

Reset
REQ-019 SHALL act asynchronously on reset=0:
- FSM to IDLE, counter to 0, busy=0.
- hi=0, lo=0, hlrdata=0.
- Latched operands and temporary result cleared.
REQ-020 SHALL, on reset asserted mid-RUN, abort the operation with no commit; after release, busy stays 0 until a new accept.
REQ-021 SHALL allow a start to be accepted at the first rising edge after reset deasserts.

Verification
REQ-022 SHALL cover these directed scenarios:
- mult: a=0xFFFFFFFE (-2), b=3, mdstart, mdop=000 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu: a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div: a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same with divu, a=7, b=2 -> lo=3, hi=1.
- Flush/ignore:
  - mdstart=1 with req=1 -> busy stays 0, hi/lo unchanged.
  - hlwrite during busy -> ignored.
  - mdstart during busy -> ignored; the first result commits correctly.
- hlwrite: hlsel=1, a=0x12345678 -> next edge hi=0x12345678, lo unchanged, hlrdata=0x12345678; hlsel=0 -> hlrdata=lo.
- Reset: assert reset=0 at cycle 3 of a div -> immediately busy=0, hi=lo=0, and no later commit; divide-by-zero -> hi/lo unchanged after 10 cycles.
